// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns MemRead/MemWrite into one bus_req/bus_ack handshake and
// returns a one-cycle MemReady pulse. Define MEM_TIMEOUT_EN to abort transfers that are never acknowledged.
module mem_bus_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              MemReady,
  output logic              MemErr,
  output logic              Busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bus_ctrl: TIMEOUT must lie in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                mem_ready_q, mem_ready_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    mem_ready_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // A simultaneous read+write request is a write because bus_we takes MemWrite.
        if (MemRead || MemWrite) begin
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = MemWrite;
          bus_addr_d  = Addr;
          bus_wdata_d = WrData;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d  = 8'd0;
`endif
        end
      end

      BUSY: begin
        // bus_ack is checked first so it beats a timeout that expires in the same cycle.
        if (bus_ack) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          mem_ready_d = 1'b1;
          if (!bus_we_q) begin
            rd_data_d = bus_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt_q + 8'd1 == TIMEOUT_C) begin
          state_d     = ABORT;
          bus_req_d   = 1'b0;
          mem_ready_d = 1'b1;
          mem_err_d   = 1'b1;
          wait_cnt_d  = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d  = wait_cnt_q + 8'd1;
        end
`endif
      end

      // Requests seen here are dropped; the requester must hold them into IDLE.
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
      mem_ready_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
      mem_ready_q <= mem_ready_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  assign Busy      = (state_q != IDLE);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign RdData    = rd_data_q;
  assign MemReady  = mem_ready_q;

`ifdef MEM_TIMEOUT_EN
  assign MemErr = mem_err_q;
`else
  assign MemErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: read/write handshakes, simultaneous request, wait/timeout,
// reset mid-transfer and ignored requests, each comparison an immediate assertion.
module tb_mem_bus_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] RdData;
  logic              MemReady;
  logic              MemErr;
  logic              Busy;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [DATA_W-1:0] exp_rd;

  mem_bus_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .MemReady (MemReady),
    .MemErr   (MemErr),
    .Busy     (Busy),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WrData = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // Asynchronous reset, before any clock edge
    #1 Reset = 1'b1;
    #1;
    check("rst_bus_req",   bus_req,   0);
    check("rst_mem_ready", MemReady,  0);
    check("rst_mem_err",   MemErr,    0);
    check("rst_busy",      Busy,      0);
    check("rst_bus_we",    bus_we,    0);
    check("rst_bus_addr",  bus_addr,  0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rd_data",   RdData,    0);
    repeat (2) tick();
    Reset = 1'b0;
    tick();
    check("idle_busy", Busy, 0);

    // Read, ack in first BUSY cycle
    Addr = 16'h0040; MemRead = 1'b1;
    tick();
    MemRead = 1'b0; Addr = 16'hFFFF;
    check("rd_busy",      Busy,      1);
    check("rd_bus_req",   bus_req,   1);
    check("rd_bus_we",    bus_we,    0);
    check("rd_bus_addr",  bus_addr,  16'h0040);
    check("rd_ready_n1",  MemReady,  0);
    bus_ack = 1'b1; bus_rdata = 16'h1234;
    tick();
    bus_ack = 1'b0; bus_rdata = 16'h0000;
    check("rd_ready_n2",  MemReady,  1);
    check("rd_err",       MemErr,    0);
    check("rd_data",      RdData,    16'h1234);
    check("rd_done_req",  bus_req,   0);
    tick();
    check("rd_ready_off", MemReady,  0);
    check("rd_idle",      Busy,      0);
    exp_rd = 16'h1234;

    // bus_ack while IDLE is ignored
    bus_ack = 1'b1; bus_rdata = 16'h9999;
    tick();
    bus_ack = 1'b0;
    check("stray_ack_busy",  Busy,     0);
    check("stray_ack_ready", MemReady, 0);
    check("stray_ack_rd",    RdData,   exp_rd);

    // Write, ack in third BUSY cycle
    Addr = 16'h0010; WrData = 16'hBEEF; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0; Addr = 16'h0000; WrData = 16'h0000; bus_rdata = 16'hDEAD;
    for (int i = 1; i <= 3; i++) begin
      check("wr_bus_req",   bus_req,   1);
      check("wr_bus_we",    bus_we,    1);
      check("wr_bus_wdata", bus_wdata, 16'hBEEF);
      check("wr_bus_addr",  bus_addr,  16'h0010);
      check("wr_ready_early", MemReady, 0);
      if (i == 3) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    check("wr_ready",    MemReady, 1);
    check("wr_err",      MemErr,   0);
    check("wr_rd_keep",  RdData,   exp_rd);
    check("wr_done_req", bus_req,  0);
    // Request raised only during DONE must not be taken
    MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
    check("done_req_ready", MemReady, 0);
    check("done_req_busy",  Busy,     0);
    tick();
    check("done_req_dropped", Busy, 0);

    // Simultaneous read+write -> write; ack on the TIMEOUT-th BUSY cycle
    Addr = 16'h0080; WrData = 16'hCAFE; MemRead = 1'b1; MemWrite = 1'b1;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("sim_bus_req", bus_req,  1);
      check("sim_bus_we",  bus_we,   1);
      check("sim_ready",   MemReady, 0);
      if (i == TIMEOUT) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    check("sim_done_ready", MemReady, 1);
    check("sim_done_err",   MemErr,   0);
    check("sim_rd_keep",    RdData,   exp_rd);
    tick();
    check("sim_idle", Busy, 0);

    // Read that is never acknowledged
    Addr = 16'h00A0; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("to_bus_req", bus_req,  1);
      check("to_ready",   MemReady, 0);
      tick();
    end
    check("to_abort_ready", MemReady, 1);
    check("to_abort_err",   MemErr,   1);
    check("to_abort_req",   bus_req,  0);
    check("to_rd_keep",     RdData,   exp_rd);
    tick();
    check("to_ready_off", MemReady, 0);
    check("to_err_off",   MemErr,   0);
    check("to_idle",      Busy,     0);
`else
    for (int i = 1; i <= 100; i++) begin
      check("wait_bus_req", bus_req,  1);
      check("wait_ready",   MemReady, 0);
      check("wait_err",     MemErr,   0);
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 16'h5678;
    tick();
    bus_ack = 1'b0;
    check("wait_done_ready", MemReady, 1);
    check("wait_done_err",   MemErr,   0);
    check("wait_rd",         RdData,   16'h5678);
    tick();
    check("wait_idle", Busy, 0);
`endif

    // Reset asserted in BUSY cycle 2
    Addr = 16'h0020; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
    tick();
    check("mr_busy2_req", bus_req, 1);
    Reset = 1'b1;
    #1;
    check("mr_req_drop", bus_req,  0);
    check("mr_busy",     Busy,     0);
    check("mr_rd_clear", RdData,   0);
    check("mr_ready",    MemReady, 0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mr_no_ready", MemReady, 0);
      check("mr_no_busy",  Busy,     0);
      tick();
    end
    Addr = 16'h0030; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
    check("mr2_bus_addr", bus_addr, 16'h0030);
    check("mr2_bus_req",  bus_req,  1);
    bus_ack = 1'b1; bus_rdata = 16'h0A0A;
    tick();
    bus_ack = 1'b0;
    check("mr2_ready", MemReady, 1);
    check("mr2_rd",    RdData,   16'h0A0A);
    tick();

    // MemWrite pulsed while a read is in BUSY is ignored
    Addr = 16'h0050; MemRead = 1'b1;
    tick();
    MemRead = 1'b0; MemWrite = 1'b1; Addr = 16'h0060; WrData = 16'h1111;
    tick();
    MemWrite = 1'b0;
    check("ign_bus_we",   bus_we,   0);
    check("ign_bus_addr", bus_addr, 16'h0050);
    bus_ack = 1'b1; bus_rdata = 16'h7777;
    tick();
    bus_ack = 1'b0;
    check("ign_ready", MemReady, 1);
    check("ign_rd",    RdData,   16'h7777);
    tick();
    check("ign_idle1", Busy, 0);
    tick();
    check("ign_idle2",     Busy,    0);
    check("ign_no_second", bus_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
